// File: rtl/llmint8_quantizer_arbiter.sv
// rtl/llmint8_quantizer_arbiter.sv - round-robin burst arbiter sharing one int8 quantizer between two requesters
// An in-order tag FIFO remembers each forwarded beat's owner so results can be steered back.
module llmint8_quantizer_arbiter #(
  parameter int IN_WIDTH       = 16,
  parameter int IN_SIZE        = 4,
  parameter int IN_PARALLELISM = 1,
  parameter int OUT_WIDTH      = 8,
  parameter int MAX_NUM_WIDTH  = 16,
  parameter int BURST_LEN      = 4,
  parameter int TAG_DEPTH      = 4
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [IN_WIDTH*IN_PARALLELISM*IN_SIZE-1:0]    req0_data,
  input  logic                                          req0_valid,
  output logic                                          req0_ready,
  input  logic [IN_WIDTH*IN_PARALLELISM*IN_SIZE-1:0]    req1_data,
  input  logic                                          req1_valid,
  output logic                                          req1_ready,
  output logic [IN_WIDTH*IN_PARALLELISM*IN_SIZE-1:0]    q_data_in,
  output logic                                          q_data_in_valid,
  input  logic                                          q_data_in_ready,
  input  logic [OUT_WIDTH*IN_PARALLELISM*IN_SIZE-1:0]   q_data_out,
  input  logic [MAX_NUM_WIDTH-1:0]                      q_max_num,
  input  logic                                          q_data_out_valid,
  output logic                                          q_data_out_ready,
  output logic [OUT_WIDTH*IN_PARALLELISM*IN_SIZE-1:0]   resp0_data,
  output logic [MAX_NUM_WIDTH-1:0]                      resp0_max_num,
  output logic                                          resp0_valid,
  input  logic                                          resp0_ready,
  output logic [OUT_WIDTH*IN_PARALLELISM*IN_SIZE-1:0]   resp1_data,
  output logic [MAX_NUM_WIDTH-1:0]                      resp1_max_num,
  output logic                                          resp1_valid,
  input  logic                                          resp1_ready,
  output logic [1:0]                                    grant,
  output logic                                          busy
);

  localparam int BCW = $clog2(BURST_LEN + 1);
  localparam int PW  = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CW  = $clog2(TAG_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t         state, state_next;
  logic           rr_ptr, rr_next;
  logic [BCW-1:0] beat_cnt, cnt_next;
  logic           owner, sel_valid, push, pop;

  logic           tag_mem [TAG_DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  tag_count;
  logic           tag_full, tag_empty, head_tag;

  assign tag_full  = (tag_count == CW'(TAG_DEPTH));
  assign tag_empty = (tag_count == '0);
  assign head_tag  = tag_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= 1'b0;
      beat_cnt <= '0;
    end else begin
      state    <= state_next;
      rr_ptr   <= rr_next;
      beat_cnt <= cnt_next;
    end
  end

  always_comb begin
    state_next      = state;
    rr_next         = rr_ptr;
    cnt_next        = beat_cnt;
    owner           = 1'b0;
    sel_valid       = 1'b0;
    push            = 1'b0;
    q_data_in       = '0;
    q_data_in_valid = 1'b0;
    req0_ready      = 1'b0;
    req1_ready      = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid && req1_valid) state_next = rr_ptr ? GRANT1 : GRANT0;
        else if (req0_valid)          state_next = GRANT0;
        else if (req1_valid)          state_next = GRANT1;
      end
      GRANT0, GRANT1: begin
        owner           = (state == GRANT1);
        sel_valid       = owner ? req1_valid : req0_valid;
        q_data_in       = owner ? req1_data : req0_data;
        q_data_in_valid = sel_valid & ~tag_full;
        req0_ready      = ~owner & q_data_in_ready & ~tag_full;
        req1_ready      = owner & q_data_in_ready & ~tag_full;
        push            = q_data_in_valid & q_data_in_ready;
        // Release on a valid gap or on the burst-completing beat; always via IDLE.
        if (!sel_valid || (push && beat_cnt == BCW'(BURST_LEN - 1))) begin
          state_next = IDLE;
          cnt_next   = '0;
          rr_next    = ~owner;
        end else if (push) begin
          cnt_next = beat_cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      tag_count <= '0;
    end else begin
      if (push) begin
        tag_mem[wr_ptr] <= owner;
        wr_ptr <= (wr_ptr == PW'(TAG_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == PW'(TAG_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   tag_count <= tag_count + 1'b1;
        2'b01:   tag_count <= tag_count - 1'b1;
        default: tag_count <= tag_count;
      endcase
    end
  end

  // Return path follows the FIFO head; nothing is accepted from the quantizer without a tag.
  assign resp0_valid      = q_data_out_valid & ~tag_empty & ~head_tag;
  assign resp1_valid      = q_data_out_valid & ~tag_empty & head_tag;
  assign q_data_out_ready = ~tag_empty & (head_tag ? resp1_ready : resp0_ready);
  assign pop              = q_data_out_valid & q_data_out_ready;
  assign resp0_data       = q_data_out;
  assign resp1_data       = q_data_out;
  assign resp0_max_num    = q_max_num;
  assign resp1_max_num    = q_max_num;

  assign grant = {state == GRANT1, state == GRANT0};
  assign busy  = (state != IDLE) | ~tag_empty;

  result_without_tag: assert property (@(posedge clk) disable iff (rst) !(q_data_out_valid && tag_empty));

endmodule

// File: tb/tb_llmint8_quantizer_arbiter.sv
// tb/tb_llmint8_quantizer_arbiter.sv - directed table-driven bench for llmint8_quantizer_arbiter
// Quantizer stand-in has 1-cycle latency; a per-port scoreboard checks results in acceptance order.
module tb_llmint8_quantizer_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] req0_data, req1_data, q_data_in;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic        q_data_in_valid, q_data_in_ready;
  logic [31:0] q_data_out, resp0_data, resp1_data;
  logic [15:0] q_max_num, resp0_max_num, resp1_max_num;
  logic        q_data_out_valid, q_data_out_ready;
  logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic [1:0]  grant;
  logic        busy;

  llmint8_quantizer_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_data(req0_data), .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req1_data(req1_data), .req1_valid(req1_valid), .req1_ready(req1_ready),
    .q_data_in(q_data_in), .q_data_in_valid(q_data_in_valid), .q_data_in_ready(q_data_in_ready),
    .q_data_out(q_data_out), .q_max_num(q_max_num), .q_data_out_valid(q_data_out_valid),
    .q_data_out_ready(q_data_out_ready),
    .resp0_data(resp0_data), .resp0_max_num(resp0_max_num), .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_data(resp1_data), .resp1_max_num(resp1_max_num), .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v0;
    logic       v1;
    logic [1:0] g;
    logic       r0;
    logic       r1;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int seq0 = 0;
  int seq1 = 0;
  int recv0, recv1;
  logic [47:0] mq [$];
  logic [47:0] exp0 [$];
  logic [47:0] exp1 [$];
  vec_t tbl [$];

  function automatic logic [63:0] mk(input int p, input int s);
    logic [63:0] r;
    for (int i = 0; i < 4; i++) r[i*16 +: 16] = {p[1:0], s[5:0], 8'(i * 37 + s * 11)};
    return r;
  endfunction

  function automatic logic [47:0] quant(input logic [63:0] d);
    logic [31:0] o;
    logic [15:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      o[i*8 +: 8] = d[i*16+8 +: 8] ^ d[i*16 +: 8];
      if (d[i*16 +: 16] > m) m = d[i*16 +: 16];
    end
    return {o, m};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Quantizer stand-in: one-cycle latency, holds results while back-pressured.
  always @(posedge clk) begin
    if (rst) mq.delete();
    else begin
      if (q_data_out_valid && q_data_out_ready) void'(mq.pop_front());
      if (q_data_in_valid && q_data_in_ready) mq.push_back(quant(q_data_in));
    end
    q_data_out_valid <= (mq.size() != 0);
    {q_data_out, q_max_num} <= (mq.size() != 0) ? mq[0] : 48'h0;
  end

  // Scoreboard: expectations come from requester-side handshakes.
  always @(posedge clk) begin
    if (rst) begin
      exp0.delete();
      exp1.delete();
      recv0 = 0;
      recv1 = 0;
    end else begin
      if (resp0_valid && resp0_ready) begin
        if (exp0.size() == 0) check("resp0_unexpected", 1, 0);
        else begin
          check("resp0_data", resp0_data, exp0[0][47:16]);
          check("resp0_max", resp0_max_num, exp0[0][15:0]);
          void'(exp0.pop_front());
        end
        recv0++;
      end
      if (resp1_valid && resp1_ready) begin
        if (exp1.size() == 0) check("resp1_unexpected", 1, 0);
        else begin
          check("resp1_data", resp1_data, exp1[0][47:16]);
          check("resp1_max", resp1_max_num, exp1[0][15:0]);
          void'(exp1.pop_front());
        end
        recv1++;
      end
      if (req0_valid && req0_ready) exp0.push_back(quant(req0_data));
      if (req1_valid && req1_ready) exp1.push_back(quant(req1_data));
    end
  end

  function automatic vec_t v(input logic v0, input logic v1, input logic [1:0] g, input logic r0, input logic r1);
    vec_t x;
    x.v0 = v0; x.v1 = v1; x.g = g; x.r0 = r0; x.r1 = r1;
    return x;
  endfunction

  task automatic add(input int n, input vec_t x);
    for (int i = 0; i < n; i++) tbl.push_back(x);
  endtask

  // Called #1 after a rising edge; returns #1 after the next one.
  task automatic drive(input vec_t x);
    logic hs0, hs1;
    req0_valid = x.v0;
    req1_valid = x.v1;
    @(negedge clk);
    check("grant", grant, x.g);
    check("req0_ready", req0_ready, x.r0);
    check("req1_ready", req1_ready, x.r1);
    hs0 = req0_valid & req0_ready;
    hs1 = req1_valid & req1_ready;
    @(posedge clk);
    #1;
    if (hs0) begin seq0++; req0_data = mk(0, seq0); end
    if (hs1) begin seq1++; req1_data = mk(1, seq1); end
  endtask

  task automatic run_table();
    for (int i = 0; i < tbl.size(); i++) drive(tbl[i]);
    tbl.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain(input int n0, input int n1);
    int t;
    t = 0;
    while ((exp0.size() != 0 || exp1.size() != 0) && t < 40) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (t >= 40) check("drain_timeout", 1, 0);
    check("recv0_count", recv0, n0);
    check("recv1_count", recv1, n1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data = mk(0, 0);
    req1_data = mk(1, 0);
    q_data_in_ready = 1'b1;
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;

    // 1: reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_grant", grant, 2'b00);
    check("rst_busy", busy, 0);
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    check("rst_q_valid", q_data_in_valid, 0);
    check("rst_q_data", q_data_in, 0);
    check("rst_resp0_valid", resp0_valid, 0);
    check("rst_resp1_valid", resp1_valid, 0);
    check("rst_q_out_ready", q_data_out_ready, 0);
    check("rst_resp0_data", resp0_data, 0);
    check("rst_resp0_max", resp0_max_num, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 2: single requester, 6 beats, burst of 4 then dead cycle
    add(1, v(1, 0, 2'b00, 0, 0));
    add(4, v(1, 0, 2'b01, 1, 0));
    add(1, v(1, 0, 2'b00, 0, 0));
    add(2, v(1, 0, 2'b01, 1, 0));
    add(1, v(0, 0, 2'b01, 1, 0));
    add(1, v(0, 0, 2'b00, 0, 0));
    run_table();
    drain(6, 0);

    // 3: both streaming, alternating 4-beat bursts starting at port 0
    do_reset();
    add(1, v(1, 1, 2'b00, 0, 0));
    add(4, v(1, 1, 2'b01, 1, 0));
    add(1, v(1, 1, 2'b00, 0, 0));
    add(4, v(1, 1, 2'b10, 0, 1));
    add(1, v(1, 1, 2'b00, 0, 0));
    add(4, v(1, 1, 2'b01, 1, 0));
    add(1, v(0, 1, 2'b00, 0, 0));
    add(4, v(0, 1, 2'b10, 0, 1));
    add(1, v(0, 0, 2'b00, 0, 0));
    run_table();
    drain(8, 8);

    // 4: response back-pressure fills the tag FIFO, then flow resumes
    do_reset();
    resp0_ready = 1'b0;
    add(1, v(1, 0, 2'b00, 0, 0));
    add(4, v(1, 0, 2'b01, 1, 0));
    add(1, v(1, 0, 2'b00, 0, 0));
    add(3, v(1, 0, 2'b01, 0, 0));
    run_table();
    check("full_q_valid", q_data_in_valid, 0);
    check("full_busy", busy, 1);
    resp0_ready = 1'b1;
    add(1, v(1, 0, 2'b01, 0, 0));
    add(4, v(1, 0, 2'b01, 1, 0));
    add(1, v(0, 0, 2'b00, 0, 0));
    run_table();
    drain(8, 0);

    // 5: port 1 drops valid mid-burst; pointer moves to port 0
    do_reset();
    add(1, v(0, 1, 2'b00, 0, 0));
    add(2, v(0, 1, 2'b10, 0, 1));
    add(1, v(1, 0, 2'b10, 0, 1));
    add(1, v(1, 1, 2'b00, 0, 0));
    add(1, v(1, 1, 2'b01, 1, 0));
    add(1, v(0, 0, 2'b01, 1, 0));
    add(1, v(0, 0, 2'b00, 0, 0));
    run_table();
    drain(1, 2);

    // 6: reset with 3 beats in flight drops them
    do_reset();
    resp0_ready = 1'b0;
    add(1, v(1, 0, 2'b00, 0, 0));
    add(3, v(1, 0, 2'b01, 1, 0));
    run_table();
    check("inflight_busy", busy, 1);
    rst = 1'b1;
    req0_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    resp0_ready = 1'b1;
    check("post_rst_grant", grant, 2'b00);
    check("post_rst_busy", busy, 0);
    check("post_rst_q_out_ready", q_data_out_ready, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_resp0_valid", resp0_valid, 0);
      check("post_rst_resp1_valid", resp1_valid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
